// File: rtl/vector_instr_receiver.sv
// Vector-side endpoint of the scalar-to-vector instruction channel.
// Accepted packets are filtered on the OP-V opcode. Legal packets are queued
// in a small FIFO. The head entry is decoded into OP-V fields and the two
// scalar operands for the vector issue stage.
module vector_instr_receiver #(
    parameter int DATA_FROM_SCALAR = 96,
    parameter int DEPTH            = 4,
    parameter int CNT_W            = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_FROM_SCALAR-1:0] in_rsc_dat,
    input  logic                        in_rsc_vld,
    output logic                        in_rsc_rdy,
    input  logic                        flush,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [5:0]                  out_funct6,
    output logic                        out_vm,
    output logic [4:0]                  out_vs2,
    output logic [4:0]                  out_vs1,
    output logic [2:0]                  out_funct3,
    output logic [4:0]                  out_vd,
    output logic [31:0]                 out_op1,
    output logic [31:0]                 out_op2,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic [CNT_W-1:0]            illegal_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    // The opcode is not stored: only instr[31:7] plus both operands are needed downstream.
    localparam int ENTRY_W = 25 + 64;

    localparam logic [6:0]       OPCODE_OPV = 7'h57;
    localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_EMPTY  = {OCC_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [OCC_W-1:0]   occ_r;
    logic [CNT_W-1:0]   illegal_cnt_r;

    logic [31:0]        instr_s;
    logic               push_s;
    logic               legal_s;
    logic               illegal_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] head_s;

    // Ready depends only on registered occupancy and the reset pin.
    assign in_rsc_rdy  = rst && (occ_r != OCC_FULL);
    assign out_vld     = (occ_r != OCC_EMPTY);
    assign occupancy   = occ_r;
    assign illegal_cnt = illegal_cnt_r;

    // Handshake qualification and opcode classification of the incoming packet.
    always_comb begin
        instr_s   = in_rsc_dat[95:64];
        push_s    = in_rsc_vld && in_rsc_rdy;
        legal_s   = 1'b0;
        illegal_s = 1'b0;
        pop_s     = out_vld && out_rdy;
        if (push_s) begin
            if (instr_s[6:0] == OPCODE_OPV) begin
                legal_s = 1'b1;
            end else begin
                illegal_s = 1'b1;
            end
        end else begin
            legal_s   = 1'b0;
            illegal_s = 1'b0;
        end
    end

    // Decode the head entry into the OP-V fields and scalar operands.
    always_comb begin
        head_s     = mem_r[rd_ptr_r];
        out_funct6 = head_s[88:83];
        out_vm     = head_s[82];
        out_vs2    = head_s[81:77];
        out_vs1    = head_s[76:72];
        out_funct3 = head_s[71:69];
        out_vd     = head_s[68:64];
        out_op1    = head_s[63:32];
        out_op2    = head_s[31:0];
    end

    // Packet storage; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (legal_s && !flush) begin
            mem_r[wr_ptr_r] <= {instr_s[31:7], in_rsc_dat[63:0]};
        end
    end

    // Pointer and occupancy bookkeeping; flush drops everything including this cycle's push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= OCC_EMPTY;
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= OCC_EMPTY;
        end else begin
            if (legal_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({legal_s, pop_s})
                2'b10:   occ_r <= occ_r + 1'b1;
                2'b01:   occ_r <= occ_r - 1'b1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Saturating count of dropped non-OP-V packets; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_cnt_r <= {CNT_W{1'b0}};
        end else if (illegal_s && (illegal_cnt_r != CNT_MAX)) begin
            illegal_cnt_r <= illegal_cnt_r + 1'b1;
        end
    end

endmodule

// File: tb/tb_vector_instr_receiver.sv
// Self-checking bench for vector_instr_receiver: a directed vector table,
// hand-written corner sequences and randomized traffic, all checked against
// a queue-based reference model of the FIFO/filter behaviour.
module tb_vector_instr_receiver;

    localparam int DEPTH   = 4;
    localparam int CNT_MAX = 255;

    logic        clk;
    logic        rst;
    logic [95:0] in_rsc_dat;
    logic        in_rsc_vld;
    logic        in_rsc_rdy;
    logic        flush;
    logic        out_vld;
    logic        out_rdy;
    logic [5:0]  out_funct6;
    logic        out_vm;
    logic [4:0]  out_vs2;
    logic [4:0]  out_vs1;
    logic [2:0]  out_funct3;
    logic [4:0]  out_vd;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [2:0]  occupancy;
    logic [7:0]  illegal_cnt;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } pkt_t;

    // Reference model state: queue of legal packets in acceptance order.
    pkt_t model_q[$];
    int   model_cnt;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        ordy;
        logic        fl;
        logic        e_vld;
        int          e_occ;
        logic        e_rdy;
        int          e_cnt;
    } vec_t;

    vec_t tbl[9];

    vector_instr_receiver #(
        .DATA_FROM_SCALAR(96),
        .DEPTH(DEPTH),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_rsc_dat(in_rsc_dat),
        .in_rsc_vld(in_rsc_vld),
        .in_rsc_rdy(in_rsc_rdy),
        .flush(flush),
        .out_vld(out_vld),
        .out_rdy(out_rdy),
        .out_funct6(out_funct6),
        .out_vm(out_vm),
        .out_vs2(out_vs2),
        .out_vs1(out_vs1),
        .out_funct3(out_funct3),
        .out_vd(out_vd),
        .out_op1(out_op1),
        .out_op2(out_op2),
        .occupancy(occupancy),
        .illegal_cnt(illegal_cnt)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the reference model's current state.
    task automatic model_check();
        chk("m_out_vld", 32'(out_vld), 32'(model_q.size() != 0));
        chk("m_occupancy", 32'(occupancy), 32'(model_q.size()));
        chk("m_in_rsc_rdy", 32'(in_rsc_rdy), 32'(model_q.size() != DEPTH));
        chk("m_illegal_cnt", 32'(illegal_cnt), 32'(model_cnt));
        if (model_q.size() != 0) begin
            chk("m_funct6", 32'(out_funct6), 32'(model_q[0].instr[31:26]));
            chk("m_vm", 32'(out_vm), 32'(model_q[0].instr[25]));
            chk("m_vs2", 32'(out_vs2), 32'(model_q[0].instr[24:20]));
            chk("m_vs1", 32'(out_vs1), 32'(model_q[0].instr[19:15]));
            chk("m_funct3", 32'(out_funct3), 32'(model_q[0].instr[14:12]));
            chk("m_vd", 32'(out_vd), 32'(model_q[0].instr[11:7]));
            chk("m_op1", out_op1, model_q[0].rs1);
            chk("m_op2", out_op2, model_q[0].rs2);
        end
    endtask

    // One clock cycle: check current outputs, drive inputs, advance model, wait for the edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic r, input logic f);
        bit   acc;
        bit   pop;
        pkt_t p;
        model_check();
        in_rsc_vld = v;
        in_rsc_dat = {ins, a, b};
        out_rdy    = r;
        flush      = f;
        acc = v && (model_q.size() != DEPTH);
        pop = r && (model_q.size() != 0);
        if (acc && (ins[6:0] != 7'h57) && (model_cnt < CNT_MAX)) model_cnt++;
        if (f) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (acc && (ins[6:0] == 7'h57)) begin
                p.instr = ins;
                p.rs1   = a;
                p.rs2   = b;
                model_q.push_back(p);
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_legal();
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], 7'h57};
    endfunction

    initial begin
        logic [31:0] pk [5];
        checks     = 0;
        failures   = 0;
        model_cnt  = 0;
        rst        = 1'b0;
        in_rsc_vld = 1'b0;
        in_rsc_dat = 96'd0;
        out_rdy    = 1'b0;
        flush      = 1'b0;

        tbl[0] = '{1'b1, 32'h0220_80D7, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1, 1'b1, 0};
        tbl[1] = '{1'b1, 32'h0000_0033, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1};
        tbl[2] = '{1'b1, 32'h4A31_50D7, 32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1};
        tbl[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1};
        tbl[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1};
        tbl[5] = '{1'b1, 32'h1234_5657, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1};
        tbl[6] = '{1'b1, 32'h0000_00D7, 32'h0000_0007, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1};
        tbl[7] = '{1'b1, 32'hFFFF_FFD7, 32'h0000_0009, 32'h0000_000A, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1};
        tbl[8] = '{1'b1, 32'h0000_0033, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 0, 1'b1, 2};

        // Reset held: ready must stay low.
        repeat (3) @(negedge clk);
        chk("rst_rdy_low", 32'(in_rsc_rdy), 32'd0);
        chk("rst_vld_low", 32'(out_vld), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_rdy", 32'(in_rsc_rdy), 32'd1);
        chk("idle_vld", 32'(out_vld), 32'd0);
        chk("idle_occ", 32'(occupancy), 32'd0);
        chk("idle_cnt", 32'(illegal_cnt), 32'd0);

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].instr, tbl[i].rs1, tbl[i].rs2, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d_vld", i), 32'(out_vld), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
            chk($sformatf("tbl%0d_rdy", i), 32'(in_rsc_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_cnt", i), 32'(illegal_cnt), 32'(tbl[i].e_cnt));
            if (i == 0) begin
                chk("dec_funct6", 32'(out_funct6), 32'h00);
                chk("dec_vm", 32'(out_vm), 32'd1);
                chk("dec_vs2", 32'(out_vs2), 32'd2);
                chk("dec_vs1", 32'(out_vs1), 32'd1);
                chk("dec_funct3", 32'(out_funct3), 32'd0);
                chk("dec_vd", 32'(out_vd), 32'd1);
                chk("dec_op1", out_op1, 32'h0000_0010);
                chk("dec_op2", out_op2, 32'hDEAD_BEEF);
            end
        end

        // Fill to full, hold the 5th packet, then drain.
        for (int i = 0; i < 5; i++) pk[i] = rand_legal();
        for (int i = 0; i < 4; i++) cycle(1'b1, pk[i], 32'(i), 32'(i + 100), 1'b0, 1'b0);
        chk("full_rdy", 32'(in_rsc_rdy), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        cycle(1'b1, pk[4], 32'd4, 32'd104, 1'b0, 1'b0);
        chk("full_hold_occ", 32'(occupancy), 32'd4);
        cycle(1'b1, pk[4], 32'd4, 32'd104, 1'b1, 1'b0);
        chk("pop_from_full_occ", 32'(occupancy), 32'd3);
        chk("pop_from_full_rdy", 32'(in_rsc_rdy), 32'd1);
        cycle(1'b1, pk[4], 32'd4, 32'd104, 1'b1, 1'b0);
        chk("fifth_accept_occ", 32'(occupancy), 32'd3);
        chk("fifth_order_vd", 32'(out_vd), 32'(pk[2][11:7]));
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("drain_occ", 32'(occupancy), 32'd0);
        chk("drain_vld", 32'(out_vld), 32'd0);

        // Illegal packets only: counter saturates, ready never drops.
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 32'h0000_0033, 32'(i), 32'd0, 1'b0, 1'b0);
            if (in_rsc_rdy !== 1'b1) chk("illegal_rdy", 32'(in_rsc_rdy), 32'd1);
        end
        chk("sat_cnt", 32'(illegal_cnt), 32'd255);
        chk("sat_vld", 32'(out_vld), 32'd0);
        chk("sat_rdy", 32'(in_rsc_rdy), 32'd1);

        // Continuous stream with consumer always ready.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, rand_legal(), $urandom, $urandom, 1'b1, 1'b0);
            chk("stream_occ", 32'(occupancy), 32'd1);
        end
        cycle(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("stream_end_occ", 32'(occupancy), 32'd0);

        // Flush with a simultaneous push.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_legal(), $urandom, $urandom, 1'b0, 1'b0);
        chk("pre_flush_occ", 32'(occupancy), 32'd3);
        cycle(1'b1, rand_legal(), 32'd1, 32'd2, 1'b0, 1'b1);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_vld", 32'(out_vld), 32'd0);
        chk("flush_cnt_kept", 32'(illegal_cnt), 32'd255);

        // Asynchronous reset mid-stream.
        cycle(1'b1, rand_legal(), $urandom, $urandom, 1'b0, 1'b0);
        cycle(1'b1, rand_legal(), $urandom, $urandom, 1'b0, 1'b0);
        model_check();
        in_rsc_vld = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_vld", 32'(out_vld), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_rdy", 32'(in_rsc_rdy), 32'd0);
        chk("arst_cnt", 32'(illegal_cnt), 32'd0);
        model_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] ins;
            ins = ($urandom_range(0, 9) < 8) ? rand_legal() : {$urandom} & 32'hFFFF_FF80 | 32'h0000_0033;
            cycle(1'($urandom_range(0, 3) != 0), ins, $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) < 3));
        end
        model_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
